// File: rtl/tr_ctrl_pkg.sv
// tr_ctrl_pkg: shared FSM state type, reset constants and point-index helper for the sequence step scheduler
// Contents: seq_state_t (IDLE/FETCH/READY), RST_* reset values, next_idx() wrap-around successor
package tr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, READY} seq_state_t;
  localparam seq_state_t RST_STATE = IDLE;
  localparam logic [15:0] RST_IDX = 16'd0;
  localparam logic [15:0] RST_PRD = 16'd0;
  localparam logic [7:0] RST_OVR_CNT = 8'd0;
  // ENABLE history resets high so a level held across reset is not taken as a rising edge
  localparam logic RST_ENABLE_Q = 1'b1;
  function automatic logic [15:0] next_idx(input logic [15:0] idx, input logic [15:0] last);
    return idx >= last ? 16'd0 : idx + 16'd1;
  endfunction
endpackage

// File: rtl/seq_step_scheduler_if.sv
// seq_step_scheduler_if: timing, mode and point-fetch handshake signals of the sequence step scheduler
// master: scheduler side (drives UPDATE/LOAD/SEQ_IDX/FETCH_REQ/FETCH_IDX/OVERRUN/OVERRUN_CNT)
// slave:  environment side (drives TIME/ENABLE/SYNC/SEQ_CLK_CYCLE/SEQ_CYCLE/FETCH_ACK)
interface seq_step_scheduler_if;
  logic [8:0] TIME;
  logic ENABLE;
  logic SYNC;
  logic [15:0] SEQ_CLK_CYCLE;
  logic [15:0] SEQ_CYCLE;
  logic FETCH_ACK;
  logic UPDATE;
  logic LOAD;
  logic [15:0] SEQ_IDX;
  logic FETCH_REQ;
  logic [15:0] FETCH_IDX;
  logic OVERRUN;
  logic [7:0] OVERRUN_CNT;
  modport master (input TIME, ENABLE, SYNC, SEQ_CLK_CYCLE, SEQ_CYCLE, FETCH_ACK,
                  output UPDATE, LOAD, SEQ_IDX, FETCH_REQ, FETCH_IDX, OVERRUN, OVERRUN_CNT);
  modport slave (output TIME, ENABLE, SYNC, SEQ_CLK_CYCLE, SEQ_CYCLE, FETCH_ACK,
                 input UPDATE, LOAD, SEQ_IDX, FETCH_REQ, FETCH_IDX, OVERRUN, OVERRUN_CNT);
endinterface

// File: rtl/period_divider.sv
// period_divider: ultrasound period strobe and periods-per-point counter
// Ports: CLK, RST_N (async active-low), time_cnt (phase counter), seq_clk_cycle (periods per point - 1),
//        clr (hold count at 0), preset (load seq_clk_cycle), hold (keep count at a missed boundary),
//        update (one-cycle period strobe), step (update that ends a point)
module period_divider #(
  parameter int ULTRASOUND_CNT_CYCLE = 512
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [8:0]  time_cnt,
  input  logic [15:0] seq_clk_cycle,
  input  logic        clr,
  input  logic        preset,
  input  logic        hold,
  output logic        update,
  output logic        step
);
  import tr_ctrl_pkg::*;
  logic [15:0] prd_cnt;
  assign step = update && prd_cnt == seq_clk_cycle;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      update <= 1'b0;
      prd_cnt <= RST_PRD;
    end else begin
      update <= time_cnt == 9'(ULTRASOUND_CNT_CYCLE - 1);
      prd_cnt <= preset ? seq_clk_cycle : clr ? 16'd0 : !update ? prd_cnt :
                 !step ? prd_cnt + 16'd1 : hold ? prd_cnt : 16'd0;
    end
endmodule

// File: rtl/seq_step_scheduler.sv
// seq_step_scheduler: steps through sequence points on ultrasound period boundaries with point prefetch
// Ports: CLK, RST_N (async active-low), bus (seq_step_scheduler_if.master: timing/mode inputs,
//        UPDATE/LOAD strobes, applied and prefetch indices, fetch handshake, overrun pulse and count)
// Option: define SEQ_STEP_SCHEDULER_OVERRUN_CNT_EN to build the saturating OVERRUN_CNT counter,
//         otherwise OVERRUN_CNT is tied to 0
module seq_step_scheduler #(
  parameter int ULTRASOUND_CNT_CYCLE = 512
) (
  input logic CLK,
  input logic RST_N,
  seq_step_scheduler_if.master bus
);
  import tr_ctrl_pkg::*;
  seq_state_t state, state_nxt;
  logic enable_q, abandon_q, update, step, entry, req, ready_now, load, overrun;
  logic [15:0] seq_idx, fetch_idx;
  period_divider #(.ULTRASOUND_CNT_CYCLE(ULTRASOUND_CNT_CYCLE)) u_div (
    .CLK(CLK),
    .RST_N(RST_N),
    .time_cnt(bus.TIME),
    .seq_clk_cycle(bus.SEQ_CLK_CYCLE),
    .clr(state == IDLE),
    .preset(entry),
    .hold(overrun),
    .update(update),
    .step(step)
  );
  // Entry (ENABLE rising or SYNC) restarts the sequence and takes priority over a boundary
  assign entry = bus.ENABLE && (bus.SYNC || !enable_q);
  // The request is masked for the first cycle after entry so an abandoned fetch is visibly dropped
  assign req = state == FETCH && !abandon_q;
  // An ACK arriving in the boundary cycle itself counts as data ready
  assign ready_now = state == READY || (req && bus.FETCH_ACK);
  assign load = bus.ENABLE && !entry && step && ready_now;
  assign overrun = bus.ENABLE && !entry && step && state == FETCH && !ready_now;
  always_comb begin
    state_nxt = !bus.ENABLE ? IDLE : entry ? FETCH : load ? FETCH :
                (req && bus.FETCH_ACK) ? READY : state;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= RST_STATE;
      enable_q <= RST_ENABLE_Q;
      abandon_q <= 1'b0;
      seq_idx <= RST_IDX;
      fetch_idx <= RST_IDX;
    end else begin
      state <= state_nxt;
      enable_q <= bus.ENABLE;
      abandon_q <= entry;
      // Entry parks SEQ_IDX on the last point so the first boundary applies point 0
      seq_idx <= entry ? bus.SEQ_CYCLE : load ? fetch_idx : seq_idx;
      fetch_idx <= entry ? 16'd0 : load ? next_idx(fetch_idx, bus.SEQ_CYCLE) : fetch_idx;
    end
`ifdef SEQ_STEP_SCHEDULER_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) ovr_cnt <= RST_OVR_CNT;
    else ovr_cnt <= bus.SYNC ? 8'd0 : (overrun && ovr_cnt != 8'hff) ? ovr_cnt + 8'd1 : ovr_cnt;
  assign bus.OVERRUN_CNT = ovr_cnt;
`else
  assign bus.OVERRUN_CNT = RST_OVR_CNT;
`endif
  assign bus.UPDATE = update;
  assign bus.LOAD = load;
  assign bus.SEQ_IDX = seq_idx;
  assign bus.FETCH_REQ = req;
  assign bus.FETCH_IDX = fetch_idx;
  assign bus.OVERRUN = overrun;
endmodule

// File: tb/tb_seq_step_scheduler.sv
// tb_seq_step_scheduler: directed scoreboard bench for seq_step_scheduler
module tb_seq_step_scheduler;
  typedef struct {
    logic [15:0] idx;
    int gap;
  } exp_t;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;
  seq_step_scheduler_if bus();
  seq_step_scheduler dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_load = 0;
  int ovr_seen = 0;
  int o0;
  exp_t sb[$];
  logic chk_seq = 1'b0;
  logic [15:0] chk_val = 16'd0;
  logic mon_upd = 1'b0;
  logic ack_man_en = 1'b0;
  logic ack_man = 1'b0;
  logic ack_auto = 1'b0;
  logic ack_hold = 1'b0;
  int ack_dly = 2;
`ifdef SEQ_STEP_SCHEDULER_OVERRUN_CNT_EN
  localparam logic [7:0] OVR2 = 8'd2;
`else
  localparam logic [7:0] OVR2 = 8'd0;
`endif
  assign bus.FETCH_ACK = ack_man_en ? ack_man : ack_auto;
  initial begin
    bus.TIME = 9'd0;
    forever begin
      @(posedge CLK);
      #1 bus.TIME = bus.TIME == 9'd511 ? 9'd0 : bus.TIME + 9'd1;
    end
  end
  // Point memory model: acknowledges a request ack_dly cycles after it is seen, one-cycle pulse
  initial begin
    int n;
    n = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (ack_auto) begin
        ack_auto = 1'b0;
        n = 0;
      end else if (bus.FETCH_REQ && !ack_hold) begin
        n++;
        ack_auto = n >= ack_dly;
      end else n = 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  task automatic push(input logic [15:0] idx, input int gap);
    exp_t e;
    e.idx = idx;
    e.gap = gap;
    sb.push_back(e);
  endtask
  // One clock: scoreboard/monitor work at the falling edge, then return 1 time unit after the rising edge
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    cyc++;
    if (chk_seq) chk("sb_seq_idx", 32'(bus.SEQ_IDX), 32'(chk_val));
    chk_seq = 1'b0;
    if (mon_upd) chk("update_phase", 32'(bus.UPDATE), 32'(bus.TIME == 9'd0));
    if (bus.OVERRUN === 1'b1) ovr_seen++;
    if (bus.LOAD === 1'b1) begin
      chk("load_with_update", 32'(bus.UPDATE), 32'd1);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_load observed FETCH_IDX %0d expected no load", bus.FETCH_IDX);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_load_idx", 32'(bus.FETCH_IDX), 32'(e.idx));
        if (e.gap != 0) chk("sb_load_gap", 32'(cyc - last_load), 32'(e.gap));
        chk_seq = 1'b1;
        chk_val = e.idx;
      end
      last_load = cyc;
    end
    @(posedge CLK);
    #1;
  endtask
  task automatic goto_t(input logic [8:0] v);
    tick();
    for (int i = 0; i < 600 && bus.TIME != v; i++) tick();
  endtask
  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) tick();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_timeout observed %0d pending loads expected 0", sb.size());
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_update"}, 32'(bus.UPDATE), 32'd0);
    chk({tag, "_load"}, 32'(bus.LOAD), 32'd0);
    chk({tag, "_seq_idx"}, 32'(bus.SEQ_IDX), 32'd0);
    chk({tag, "_fetch_req"}, 32'(bus.FETCH_REQ), 32'd0);
    chk({tag, "_fetch_idx"}, 32'(bus.FETCH_IDX), 32'd0);
    chk({tag, "_overrun"}, 32'(bus.OVERRUN), 32'd0);
    chk({tag, "_overrun_cnt"}, 32'(bus.OVERRUN_CNT), 32'd0);
  endtask
  initial begin
    bus.ENABLE = 1'b0;
    bus.SYNC = 1'b0;
    bus.SEQ_CLK_CYCLE = 16'd0;
    bus.SEQ_CYCLE = 16'd3;
    #1 RST_N = 1'b0;
    #1 chk_all_zero("reset");
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    goto_t(9'd1);
    mon_upd = 1'b1;
    // One-period steps over points 0..3
    goto_t(9'd100);
    bus.ENABLE = 1'b1;
    push(16'd0, 0);
    push(16'd1, 512);
    push(16'd2, 512);
    push(16'd3, 512);
    push(16'd0, 512);
    tick();
    chk("entry_seq_idx", 32'(bus.SEQ_IDX), 32'd3);
    chk("entry_fetch_idx", 32'(bus.FETCH_IDX), 32'd0);
    tick();
    chk("entry_fetch_req", 32'(bus.FETCH_REQ), 32'd1);
    wait_empty(5 * 512 + 600);
    chk("t1_seq_idx", 32'(bus.SEQ_IDX), 32'd0);
    chk("t1_fetch_idx", 32'(bus.FETCH_IDX), 32'd1);
    chk("t1_no_overrun", 32'(ovr_seen), 32'd0);
    // ENABLE low: idle, indices retained, ACK without request ignored
    bus.ENABLE = 1'b0;
    tick();
    chk("idle_fetch_req", 32'(bus.FETCH_REQ), 32'd0);
    ack_man_en = 1'b1;
    ack_man = 1'b1;
    repeat (3) tick();
    chk("idle_ack_fetch_req", 32'(bus.FETCH_REQ), 32'd0);
    chk("idle_seq_idx", 32'(bus.SEQ_IDX), 32'd0);
    chk("idle_fetch_idx", 32'(bus.FETCH_IDX), 32'd1);
    ack_man_en = 1'b0;
    ack_man = 1'b0;
    // Three periods per point
    bus.SEQ_CLK_CYCLE = 16'd2;
    goto_t(9'd100);
    bus.ENABLE = 1'b1;
    push(16'd0, 0);
    push(16'd1, 1536);
    push(16'd2, 1536);
    wait_empty(3 * 1536 + 600);
    chk("t2_seq_idx", 32'(bus.SEQ_IDX), 32'd2);
    chk("t2_fetch_idx", 32'(bus.FETCH_IDX), 32'd3);
    // SYNC in the boundary cycle at SEQ_IDX=2
    goto_t(9'd0);
    goto_t(9'd0);
    goto_t(9'd0);
    bus.SYNC = 1'b1;
    #1;
    chk("sync_bnd_update", 32'(bus.UPDATE), 32'd1);
    chk("sync_bnd_load", 32'(bus.LOAD), 32'd0);
    chk("sync_bnd_overrun", 32'(bus.OVERRUN), 32'd0);
    tick();
    bus.SYNC = 1'b0;
    chk("sync_fetch_idx", 32'(bus.FETCH_IDX), 32'd0);
    chk("sync_seq_idx", 32'(bus.SEQ_IDX), 32'd3);
    chk("sync_ovr_cnt", 32'(bus.OVERRUN_CNT), 32'd0);
    push(16'd0, 0);
    wait_empty(700);
    chk("t3_seq_idx", 32'(bus.SEQ_IDX), 32'd0);
    // ACK withheld across two boundaries
    bus.SEQ_CLK_CYCLE = 16'd0;
    ack_hold = 1'b1;
    goto_t(9'd100);
    bus.SYNC = 1'b1;
    tick();
    bus.SYNC = 1'b0;
    o0 = ovr_seen;
    repeat (1100) tick();
    chk("ovr_pulses", 32'(ovr_seen - o0), 32'd2);
    chk("ovr_seq_idx_held", 32'(bus.SEQ_IDX), 32'd3);
    chk("ovr_fetch_req_held", 32'(bus.FETCH_REQ), 32'd1);
    chk("ovr_cnt", 32'(bus.OVERRUN_CNT), 32'(OVR2));
    ack_hold = 1'b0;
    push(16'd0, 0);
    wait_empty(700);
    chk("ovr_pulses_after", 32'(ovr_seen - o0), 32'd2);
    chk("t4_seq_idx", 32'(bus.SEQ_IDX), 32'd0);
    // SYNC mid-fetch abandons the request; ACK in the boundary cycle; SEQ_CYCLE lowered
    bus.SEQ_CYCLE = 16'd5;
    ack_man_en = 1'b1;
    ack_man = 1'b0;
    goto_t(9'd100);
    chk("pre_sync_fetch_req", 32'(bus.FETCH_REQ), 32'd1);
    bus.SYNC = 1'b1;
    tick();
    bus.SYNC = 1'b0;
    chk("abandon_fetch_req", 32'(bus.FETCH_REQ), 32'd0);
    chk("sync_clr_ovr_cnt", 32'(bus.OVERRUN_CNT), 32'd0);
    chk("t5_entry_seq_idx", 32'(bus.SEQ_IDX), 32'd5);
    tick();
    chk("refetch_req", 32'(bus.FETCH_REQ), 32'd1);
    o0 = ovr_seen;
    push(16'd0, 0);
    goto_t(9'd0);
    ack_man = 1'b1;
    #1;
    chk("bnd_ack_load", 32'(bus.LOAD), 32'd1);
    chk("bnd_ack_overrun", 32'(bus.OVERRUN), 32'd0);
    tick();
    ack_man = 1'b0;
    ack_man_en = 1'b0;
    push(16'd1, 512);
    push(16'd2, 512);
    push(16'd3, 512);
    wait_empty(3 * 512 + 100);
    push(16'd4, 512);
    goto_t(9'd0);
    bus.SEQ_CYCLE = 16'd1;
    #1;
    chk("load4", 32'(bus.LOAD), 32'd1);
    tick();
    chk("lower_seq_idx", 32'(bus.SEQ_IDX), 32'd4);
    chk("lower_next_idx", 32'(bus.FETCH_IDX), 32'd0);
    push(16'd0, 512);
    push(16'd1, 512);
    wait_empty(2 * 512 + 100);
    chk("t5_seq_idx", 32'(bus.SEQ_IDX), 32'd1);
    chk("t5_fetch_idx", 32'(bus.FETCH_IDX), 32'd0);
    chk("t5_no_overrun", 32'(ovr_seen - o0), 32'd0);
    // Asynchronous reset in the middle of a fetch, then resume only on SYNC
    bus.ENABLE = 1'b0;
    tick();
    ack_man_en = 1'b1;
    ack_man = 1'b0;
    bus.ENABLE = 1'b1;
    repeat (3) tick();
    chk("pre_rst_fetch_req", 32'(bus.FETCH_REQ), 32'd1);
    mon_upd = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (5) tick();
    chk("post_rst_fetch_req", 32'(bus.FETCH_REQ), 32'd0);
    chk("post_rst_seq_idx", 32'(bus.SEQ_IDX), 32'd0);
    bus.SYNC = 1'b1;
    tick();
    bus.SYNC = 1'b0;
    tick();
    chk("resume_fetch_req", 32'(bus.FETCH_REQ), 32'd1);
    chk("resume_seq_idx", 32'(bus.SEQ_IDX), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_step_scheduler.md
SEQ_STEP_SCHEDULER -- requirements
Module: seq_step_scheduler

Interface
REQ-001 SHALL have parameter ULTRASOUND_CNT_CYCLE, default 512: ultrasound period in CLK cycles.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-low):
  CLK  in  1  system clock
  RST_N  in  1  async active-low reset
  TIME  in  9  free-running ultrasound phase counter, 0..ULTRASOUND_CNT_CYCLE-1
  ENABLE  in  1  sequence mode active (OP_MODE)
  SYNC  in  1  one-cycle global resync pulse
  SEQ_CLK_CYCLE  in  16  ultrasound periods per point, minus 1
  SEQ_CYCLE  in  16  last point index
  FETCH_ACK  in  1  point data for FETCH_IDX is buffered
  UPDATE  out  1  one-cycle period-boundary strobe
  LOAD  out  1  one-cycle strobe: apply fetched point
  SEQ_IDX  out  16  currently applied point index
  FETCH_REQ  out  1  request prefetch of FETCH_IDX
  FETCH_IDX  out  16  point index to prefetch
  OVERRUN  out  1  one-cycle pulse: step missed, data not ready
  OVERRUN_CNT  out  8  saturating overrun count

Function
REQ-003 SHALL assert UPDATE for exactly one CLK, in the cycle after TIME equals ULTRASOUND_CNT_CYCLE-1.
REQ-004 SHALL count UPDATE pulses in period counter prd_cnt; step boundary = UPDATE with prd_cnt == SEQ_CLK_CYCLE, then prd_cnt <= 0; SEQ_CLK_CYCLE = 0 steps every period.
REQ-005 SHALL compute next index as 0 when SEQ_IDX >= SEQ_CYCLE, else SEQ_IDX+1 (16-bit, no overflow possible).
REQ-006 SHALL implement FSM states IDLE, FETCH, READY.
REQ-007 IDLE: FETCH_REQ=0, LOAD=0, prd_cnt held 0; ENABLE rising -> FETCH with FETCH_IDX=0, SEQ_IDX=SEQ_CYCLE, prd_cnt=SEQ_CLK_CYCLE (first boundary applies point 0).
REQ-008 FETCH: FETCH_REQ=1, FETCH_IDX stable; FETCH_ACK high -> READY next cycle.
REQ-009 READY: FETCH_REQ=0; at step boundary LOAD=1 coincident with UPDATE, SEQ_IDX <= FETCH_IDX, FETCH_IDX <= next index of new SEQ_IDX, -> FETCH.
REQ-010 Step boundary in FETCH with FETCH_ACK low SHALL pulse OVERRUN, suppress LOAD, hold SEQ_IDX, hold prd_cnt at SEQ_CLK_CYCLE (retry at next UPDATE), keep FETCH_REQ high.
REQ-011 FETCH_ACK high in the boundary cycle SHALL count as ready: LOAD asserted, no OVERRUN.
REQ-012 FETCH_ACK while FETCH_REQ low SHALL be ignored.
REQ-013 SYNC (with ENABLE high) SHALL behave as REQ-007 entry from any state, abandon any outstanding request (FETCH_REQ low for exactly one cycle), and win over a simultaneous boundary (no LOAD, no OVERRUN).
REQ-014 ENABLE low SHALL force IDLE next cycle; SEQ_IDX, FETCH_IDX retain value; UPDATE continues.
REQ-015 FETCH_REQ may drop without ACK only via SYNC, ENABLE low or reset.
REQ-016 OVERRUN_CNT SHALL increment on OVERRUN, saturate at 255, clear on SYNC.

Reset
REQ-017 RST_N low SHALL asynchronously force: state IDLE, UPDATE=0, LOAD=0, SEQ_IDX=0, FETCH_REQ=0, FETCH_IDX=0, OVERRUN=0, OVERRUN_CNT=0, prd_cnt=0.
REQ-018 Reset deassertion mid-fetch SHALL resume only via ENABLE rising edge or SYNC.

Configuration
REQ-019 Macro SEQ_STEP_SCHEDULER_OVERRUN_CNT_EN defined: OVERRUN_CNT per REQ-016; undefined: OVERRUN_CNT tied 0, counter logic absent, OVERRUN pulse unaffected.

Structure
REQ-020 FSM state enum and reset constants SHALL live in shared package tr_ctrl_pkg.
REQ-021 Period detection and prd_cnt SHALL be sub-module period_divider (outputs UPDATE and step boundary).

Verification
REQ-022 SEQ_CLK_CYCLE=0, SEQ_CYCLE=3, ACK 2 cycles after REQ -> LOAD every 512 CLK, SEQ_IDX 0,1,2,3,0.
REQ-023 SEQ_CLK_CYCLE=2 -> LOAD on every 3rd UPDATE, never without UPDATE.
REQ-024 ACK withheld 1100 cycles -> OVERRUN at next two boundaries, SEQ_IDX held, OVERRUN_CNT=2, LOAD at first boundary after ACK.
REQ-025 SYNC coincident with boundary at SEQ_IDX=2 -> no LOAD, FETCH_IDX=0, next boundary SEQ_IDX=0, OVERRUN_CNT=0.
REQ-026 ACK in boundary cycle -> LOAD=1, OVERRUN=0; SEQ_CYCLE lowered 5->1 at SEQ_IDX=4 -> next index 0.
REQ-027 RST_N low mid-FETCH -> all outputs 0 immediately without clock; macro undefined -> OVERRUN_CNT constant 0.
